// File: rtl/print_string_engine.sv
// Print-string syscall engine: walks a NUL-terminated byte string through a
// dedicated memory read port and streams characters to a valid/ready console sink.
module print_string_engine #(
   parameter int MAX_LEN = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] start_addr,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic        truncated,
   output logic        mem_rd_en,
   output logic [31:0] mem_rd_addr,
   input  logic [31:0] mem_rd_data,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [15:0] MAX_COUNT = 16'(MAX_LEN);

   state_t      state_r;
   state_t      state_s;
   logic [31:0] ptr_r;
   logic [31:0] ptr_s;
   logic [15:0] count_r;
   logic [15:0] count_s;
   logic [15:0] count_inc_s;
   logic [31:0] word_r;
   logic [31:0] word_s;
   logic        trunc_r;
   logic        trunc_s;
   logic [7:0]  cur_byte_s;
   logic [7:0]  next_byte_s;

   // Little-endian lane select: lane 0 is the lowest-addressed byte.
   function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign cur_byte_s  = lane_byte(word_r, ptr_r[1:0]);
   assign next_byte_s = lane_byte(word_s, ptr_s[1:0]);
   assign count_inc_s = count_r + 16'd1;
   assign stall       = start | busy;

   // Next-state and datapath update for the string walk.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      count_s = count_r;
      word_s  = word_r;
      trunc_s = trunc_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               ptr_s   = start_addr;
               count_s = 16'd0;
               trunc_s = 1'b0;
               state_s = ST_FETCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_s = ST_LOAD;
         end
         ST_LOAD: begin
            word_s  = mem_rd_data;
            state_s = ST_EMIT;
         end
         ST_EMIT: begin
            if (cur_byte_s == 8'h00) begin
               trunc_s = 1'b0;
               state_s = ST_DONE;
            end else if (char_ready) begin
               ptr_s   = ptr_r + 32'd1;
               count_s = count_inc_s;
               if (count_inc_s == MAX_COUNT) begin
                  trunc_s = 1'b1;
                  state_s = ST_DONE;
               end else if (ptr_r[1:0] == 2'd3) begin
                  state_s = ST_FETCH;
               end else begin
                  state_s = ST_EMIT;
               end
            end else begin
               state_s = ST_EMIT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Engine state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         ptr_r   <= 32'd0;
         count_r <= 16'd0;
         word_r  <= 32'd0;
         trunc_r <= 1'b0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         count_r <= count_s;
         word_r  <= word_s;
         trunc_r <= trunc_s;
      end
   end

   // Outputs are registered from the next-state values so they line up with
   // the state they describe and never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         truncated   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= 32'd0;
         char_valid  <= 1'b0;
         char_data   <= 8'h00;
      end else begin
         busy        <= (state_s == ST_FETCH) || (state_s == ST_LOAD) || (state_s == ST_EMIT);
         done        <= (state_s == ST_DONE);
         truncated   <= (state_s == ST_DONE) && trunc_s;
         mem_rd_en   <= (state_s == ST_FETCH);
         mem_rd_addr <= {2'b00, ptr_s[31:2]};
         char_valid  <= (state_s == ST_EMIT) && (next_byte_s != 8'h00);
         char_data   <= (state_s == ST_EMIT) ? next_byte_s : 8'h00;
      end
   end

endmodule

// File: tb/tb_print_string_engine.sv
// Self-checking bench for print_string_engine: directed latency/content cases
// plus randomized strings checked against a byte-walk reference model.
module tb_print_string_engine;

   localparam int MAXL = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_addr = 32'd0;
   logic        stall, busy, done, truncated, mem_rd_en, char_valid;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data = 32'd0;
   logic [7:0]  char_data;
   logic        char_ready = 1'b0;

   print_string_engine #(.MAX_LEN(MAXL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .stall(stall), .busy(busy), .done(done), .truncated(truncated),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // model state
   bit          active = 1'b0;
   logic [7:0]  exp_chars[$];
   logic [31:0] exp_fetch[$];
   bit          exp_trunc = 1'b0;
   logic [7:0]  got[$];
   int          start_cyc = 0;
   int          done_cyc = 0;
   bit          last_trunc = 1'b0;
   bit          prev_hold = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   int          mode = 0;
   int          bp = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return w[8*a[1:0] +: 8];
   endfunction

   // Reference: the characters are the bytes from the start address up to the
   // NUL or MAX_LEN; every distinct word touched by an examined byte is fetched once.
   task automatic build(input logic [31:0] a);
      logic [31:0] p;
      logic [31:0] w;
      logic [31:0] lastw;
      logic [7:0]  b;
      int          n;
      bit          first;
      p = a; n = 0; first = 1'b1; lastw = 32'd0;
      exp_chars.delete();
      exp_fetch.delete();
      exp_trunc = 1'b0;
      while (1) begin
         w = {2'b00, p[31:2]};
         if (first || w != lastw) exp_fetch.push_back(w);
         first = 1'b0;
         lastw = w;
         b = byte_at(p);
         if (b == 8'h00) break;
         exp_chars.push_back(b);
         n++;
         p = p + 32'd1;
         if (n == MAXL) begin
            exp_trunc = 1'b1;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("stall", 32'(stall), 32'(start | busy));
         chk("busy", 32'(busy), 32'(active && !done));
         if (start && !active) begin
            build(start_addr);
            active = 1'b1;
            start_cyc = cyc;
            got.delete();
         end
         if (mem_rd_en) begin
            if (exp_fetch.size() == 0) fail("fetch_extra");
            else chk("fetch_addr", mem_rd_addr, exp_fetch.pop_front());
         end
         if (char_valid) begin
            chk("char_nonzero", 32'(char_data != 8'h00), 32'd1);
            if (prev_hold) chk("hold_data", 32'(char_data), 32'(prev_data));
         end else if (prev_hold) begin
            fail("valid_drop");
         end
         prev_hold = char_valid && !char_ready;
         prev_data = char_data;
         if (char_valid && char_ready) begin
            got.push_back(char_data);
            if (exp_chars.size() == 0) fail("char_extra");
            else chk("char", 32'(char_data), 32'(exp_chars.pop_front()));
         end
         if (done) begin
            chk("done_active", 32'(active), 32'd1);
            chk("done_chars_left", 32'(exp_chars.size()), 32'd0);
            chk("done_fetch_left", 32'(exp_fetch.size()), 32'd0);
            chk("truncated", 32'(truncated), 32'(exp_trunc));
            last_trunc = truncated;
            done_cyc = cyc;
            active = 1'b0;
         end
      end else begin
         active = 1'b0;
         prev_hold = 1'b0;
         exp_chars.delete();
         exp_fetch.delete();
      end
   end

   // Sink readiness: 0 always ready, 1 random, 2 hold off first char 5 cycles, 3 never.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: char_ready = 1'b1;
            1: char_ready = ($urandom_range(0, 9) < 7);
            2: begin
               if (char_valid && bp < 5) begin
                  char_ready = 1'b0;
                  bp++;
               end else begin
                  char_ready = 1'b1;
               end
            end
            default: char_ready = 1'b0;
         endcase
      end
   end

   task automatic run_job(input logic [31:0] a, input int restart_at, input bit start_in_done,
                          output int lat);
      int t;
      t = 0;
      start = 1'b1;
      start_addr = a;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && t < 2000) begin
         @(posedge clk); #1;
         t++;
         start = (restart_at > 0 && t == restart_at);
         if (start) start_addr = $urandom;
      end
      if (!done) fail("done_timeout");
      start = start_in_done;
      start_addr = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      lat = done_cyc - start_cyc;
   endtask

   task automatic check_got(input string name, input int n, input logic [63:0] e);
      chk({name, "_len"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++) chk(name, 32'(got[i]), 32'(e[8*i +: 8]));
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      for (int k = 0; k < 4; k++)
         w[8*k +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      return w;
   endfunction

   initial begin
      int lat;
      int t;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;

      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_trunc", 32'(truncated), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_rd_addr", mem_rd_addr, 32'd0);
      chk("rst_valid", 32'(char_valid), 32'd0);
      chk("rst_data", 32'(char_data), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // aligned "Hi!\n"
      mem[8'h40] = 32'h0A216948;
      mem[8'h41] = 32'h00000000;
      run_job(32'h100, 0, 1'b0, lat);
      chk("aligned_lat", 32'(lat), 32'd10);
      chk("aligned_trunc", 32'(last_trunc), 32'd0);
      check_got("aligned_chars", 4, 64'h0A216948);

      // unaligned start crossing a word
      mem[8'h40] = 32'h62611234;
      mem[8'h41] = 32'h00000063;
      run_job(32'h102, 0, 1'b0, lat);
      chk("unaligned_lat", 32'(lat), 32'd9);
      check_got("unaligned_chars", 3, 64'h636261);

      // backpressure on the first character
      mem[8'h40] = 32'h0A216948;
      mem[8'h41] = 32'h00000000;
      bp = 0;
      mode = 2;
      run_job(32'h100, 0, 1'b0, lat);
      mode = 0;
      chk("bp_lat", 32'(lat), 32'd15);
      chk("bp_count", 32'(bp), 32'd5);
      check_got("bp_chars", 4, 64'h0A216948);

      // truncation at MAX_LEN
      for (int i = 0; i < 256; i++) mem[i] = 32'h41414141;
      run_job(32'h200, 0, 1'b0, lat);
      chk("trunc_lat", 32'(lat), 32'd11);
      chk("trunc_flag", 32'(last_trunc), 32'd1);
      check_got("trunc_chars", MAXL, 64'h414141414141);

      // empty string
      mem[8'h10] = 32'h00000000;
      run_job(32'h40, 0, 1'b0, lat);
      chk("empty_lat", 32'(lat), 32'd4);
      chk("empty_trunc", 32'(last_trunc), 32'd0);
      check_got("empty_chars", 0, 64'h0);

      // restart while busy and start in the DONE cycle are both dropped
      mem[8'h40] = 32'h0A216948;
      mem[8'h41] = 32'h00000000;
      run_job(32'h100, 3, 1'b1, lat);
      chk("restart_lat", 32'(lat), 32'd10);
      check_got("restart_chars", 4, 64'h0A216948);
      chk("restart_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("restart_idle2", 32'(busy | mem_rd_en), 32'd0);

      // reset while a character is pending
      mode = 3;
      start = 1'b1;
      start_addr = 32'h100;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (!char_valid && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("pre_reset_valid", 32'(char_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(char_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mode = 0;
      @(posedge clk); #1;
      run_job(32'h101, 0, 1'b0, lat);
      chk("post_rst_lat", 32'(lat), 32'd9);
      check_got("post_rst_chars", 3, 64'h0A2169);

      // randomized strings, addresses, backpressure and stray starts
      mode = 1;
      for (int j = 0; j < 40; j++) begin
         for (int w = 0; w < 256; w++) mem[w] = rand_word();
         run_job($urandom, $urandom_range(0, 8), 1'($urandom_range(0, 1)), lat);
      end
      mode = 0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/print_string_engine.md
# print_string_engine

Syscall print-string engine for the pipelined CPU. It sits directly downstream of the data memory. On a print-string request from the MEM stage, it walks a NUL-terminated byte string through a dedicated memory read port and streams the characters one at a time to the console sink over a valid/ready handshake. While it runs, it holds the pipeline stalled so that no store can race the walk.

## Interface
Parameters:
- MAX_LEN, default 1024: maximum characters emitted before forced termination. Range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- start  in  1  request pulse from the MEM stage (print-string syscall decoded).
- start_addr  in  32  byte address of the first character.
- stall  out  1  combinational `start | busy`, to the hazard unit.
- busy  out  1  engine walking the string.
- done  out  1  one-cycle completion pulse.
- truncated  out  1  valid with done; 1 = MAX_LEN reached without NUL.
- mem_rd_en  out  1  read request to the data-memory read port.
- mem_rd_addr  out  32  word address, `byte_addr >> 2`.
- mem_rd_data  in  32  read word. Sampled on the edge after the cycle in which mem_rd_en=1.
- char_valid  out  1  char_data holds a character.
- char_data  out  8  character, never 0x00.
- char_ready  in  1  console sink accepts.

## Operation
- State machine: IDLE, FETCH, LOAD, EMIT, DONE.
- IDLE:
  - If start=1: capture `ptr <= start_addr`, clear `count`, go to FETCH.
  - If start=0: stay in IDLE.
- FETCH:
  - mem_rd_en=1, mem_rd_addr = `ptr[31:2]` zero-extended.
  - Go to LOAD.
- LOAD:
  - Capture mem_rd_data into `word`. Go to EMIT.
- EMIT: the current byte is lane `ptr[1:0]`, little-endian (lane 0 = bits [7:0]).
  - Byte = 0x00: char_valid=0, truncated=0, go to DONE.
  - Byte nonzero: char_valid=1, char_data = byte. Hold char_valid and char_data stable until char_ready=1.
  - On transfer (char_valid & char_ready): `ptr <= ptr+1`, `count <= count+1`.
    - New count == MAX_LEN: go to DONE with truncated=1.
    - Else if old `ptr[1:0]` == 3: go to FETCH.
    - Else: stay in EMIT.
- DONE: done=1 for exactly one cycle, truncated valid, then IDLE.
- busy=1 in FETCH, LOAD and EMIT; busy=0 in IDLE and DONE.
- start is ignored unless in IDLE. start arriving in the DONE cycle is dropped, but stall is still asserted in that cycle.
- ptr wraps modulo 2^32. count is 16 bits and compared for equality against MAX_LEN.
- The word is re-fetched for every new word. No caching across requests.

## Timing
Reset values (asynchronous on rst_n=0, mid-operation included):
- State = IDLE.
- busy, done, truncated, mem_rd_en, char_valid = 0.
- char_data = 0x00, mem_rd_addr = 0.
- The abandoned string is not resumed.

Latency, with start sampled at edge E0:
- mem_rd_en=1 in cycle E0–E1.
- word captured at E2.
- First char_valid in cycle E2–E3.

Throughput:
- With char_ready held at 1: one character per cycle within a word.
- Each word boundary adds 2 bubble cycles (FETCH, LOAD).

Completion:
- NUL seen in EMIT in cycle k leads to done=1 in cycle k+1.
- Empty string: no char_valid, done in cycle E3–E4.

Handshake:
- char_valid never drops without a transfer, except on reset.
- char_data changes only after a transfer.

## Test plan
- Aligned string: mem word 0x40 = 0x0A216948, word 0x41 = 0x00000000, start_addr=0x100, char_ready=1.
  - Expect chars 0x48, 0x69, 0x21, 0x0A on 4 consecutive cycles.
  - Then one fetch of word 0x41, then done=1, truncated=0.
  - stall high from the start cycle through the last EMIT cycle.
- Unaligned start: start_addr=0x102, word 0x40 = 0x6261xxxx, word 0x41 = 0x00000063.
  - Expect chars 0x61, 0x62, then mem_rd_addr=0x41, then 0x63, then done.
- Backpressure: char_ready=0 for 5 cycles on the first char.
  - Expect char_valid=1 and char_data=0x48 held all 5 cycles.
  - Transfer on the cycle char_ready=1, and no duplicate or skipped char.
- Truncation: MAX_LEN=4, memory filled with 0x41.
  - Expect exactly 4 chars, then done=1 with truncated=1.
- Empty string and ignored restart:
  - First byte 0x00: expect zero chars and done exactly 4 cycles after start.
  - start pulsed again while busy: expect it ignored, ptr unchanged.
- Reset mid-EMIT: assert rst_n=0 while char_valid=1.
  - Expect char_valid, busy and mem_rd_en at 0 immediately.
  - After release, a new start runs normally from its own start_addr.
